hmmm_ctrl: RTL and testbench

Multicycle control sequencer for the ConfusedCore HMMM datapath. It decodes the 16-bit instruction held in the instruction register and steps it through fetch, decode, execute, memory, write-back and I/O states. Each cycle it drives every datapath write-enable and every mux select: PC source (3-way), ALU B operand (2-way), register write address (2-way) and write-back source (7-way). Instructions are non-overlapped: exactly one is in flight at any time.

---
 rtl/hmmm_pkg.sv | 45 ++++
 rtl/hmmm_decode.sv | 57 +++++
 rtl/hmmm_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_hmmm_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmmm_pkg.sv
// Shared encodings for the HMMM control sequencer: opcodes, FSM states and mux selects.
// HMMM_MULDIV_EN adds the MD_WAIT state for the mul/div/mod handshake.
package hmmm_pkg;

  localparam logic [3:0] OP_SYS    = 4'h0;
  localparam logic [3:0] OP_SETN   = 4'h1;
  localparam logic [3:0] OP_LOADN  = 4'h2;
  localparam logic [3:0] OP_STOREN = 4'h3;
  localparam logic [3:0] OP_MEMR   = 4'h4;
  localparam logic [3:0] OP_ADDN   = 4'h5;
  localparam logic [3:0] OP_ADD    = 4'h6;
  localparam logic [3:0] OP_SUB    = 4'h7;
  localparam logic [3:0] OP_MUL    = 4'h8;
  localparam logic [3:0] OP_DIV    = 4'h9;
  localparam logic [3:0] OP_MOD    = 4'hA;
  localparam logic [3:0] OP_JUMPN  = 4'hB;
  localparam logic [3:0] OP_JEQZN  = 4'hC;
  localparam logic [3:0] OP_JNEZN  = 4'hD;
  localparam logic [3:0] OP_JGTZN  = 4'hE;
  localparam logic [3:0] OP_JLTZN  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_IO_WAIT,
`ifdef HMMM_MULDIV_EN
    S_MD_WAIT,
`endif
    S_HALT
  } ctrl_state_t;

  typedef enum logic [1:0] {PC_INC = 2'd0, PC_IMM = 2'd1, PC_RX = 2'd2} pc_sel_t;

  typedef enum logic [2:0] {
    WB_ALU = 3'd0, WB_IMM = 3'd1, WB_MEM = 3'd2, WB_PC1 = 3'd3,
    WB_IO  = 3'd4, WB_MD  = 3'd5, WB_RY  = 3'd6
  } wb_sel_t;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_NEG = 2'd2, ALU_PASSB = 2'd3} alu_op_t;

  typedef enum logic [4:0] {
    C_ILL, C_HALT, C_READ, C_WRITE, C_JUMPR, C_SETN, C_LOADN, C_STOREN,
    C_LOADR, C_STORER, C_POPR, C_PUSHR, C_ADDN, C_COPY, C_ADD, C_NEG,
    C_SUB, C_MD, C_JUMPN, C_CALLN, C_JEQZ, C_JNEZ, C_JGTZ, C_JLTZ
  } instr_class_t;

endpackage

// File: rtl/hmmm_decode.sv
// Combinational HMMM instruction classifier; mul/div/mod are legal only under HMMM_MULDIV_EN.
module hmmm_decode
  import hmmm_pkg::*;
(
  input  logic [15:0]  i_instr,
  output instr_class_t o_class,
  output logic         o_illegal
);

  always_comb begin
    o_class = C_ILL;
    case (i_instr[15:12])
      OP_SYS: begin
        if (i_instr[11:0] == 12'h000) o_class = C_HALT;
        else begin
          case (i_instr[7:0])
            8'h01:   o_class = C_READ;
            8'h02:   o_class = C_WRITE;
            8'h03:   o_class = C_JUMPR;
            default: o_class = C_ILL;
          endcase
        end
      end
      OP_SETN:   o_class = C_SETN;
      OP_LOADN:  o_class = C_LOADN;
      OP_STOREN: o_class = C_STOREN;
      OP_MEMR: begin
        case (i_instr[3:0])
          4'h0:    o_class = C_LOADR;
          4'h1:    o_class = C_STORER;
          4'h2:    o_class = C_POPR;
          4'h3:    o_class = C_PUSHR;
          default: o_class = C_ILL;
        endcase
      end
      OP_ADDN:   o_class = C_ADDN;
      // copy and neg are the rZ = r0 / rY = r0 forms of add and sub
      OP_ADD:    o_class = (i_instr[3:0] == 4'h0) ? C_COPY : C_ADD;
      OP_SUB:    o_class = (i_instr[7:4] == 4'h0) ? C_NEG : C_SUB;
      OP_MUL, OP_DIV, OP_MOD: begin
`ifdef HMMM_MULDIV_EN
        o_class = C_MD;
`else
        o_class = C_ILL;
`endif
      end
      OP_JUMPN:  o_class = (i_instr[11:8] == 4'h0) ? C_JUMPN : C_CALLN;
      OP_JEQZN:  o_class = C_JEQZ;
      OP_JNEZN:  o_class = C_JNEZ;
      OP_JGTZN:  o_class = C_JGTZ;
      OP_JLTZN:  o_class = C_JLTZ;
    endcase
  end

  assign o_illegal = (o_class == C_ILL);

endmodule

// File: rtl/hmmm_ctrl.sv
// Multicycle control FSM for the HMMM datapath; one instruction in flight at a time.
// HMMM_MULDIV_EN enables the md_start/md_done handshake and the MD_WAIT state.
module hmmm_ctrl
  import hmmm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        rx_zero,
  input  logic        rx_neg,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic        rf_waddr_sel,
  output logic [2:0]  wb_sel,
  output logic [1:0]  alu_op,
  output logic        alu_b_sel,
  output logic        mem_addr_sel,
  output logic        mem_we,
  output logic        io_in_ready,
  input  logic        io_in_valid,
  output logic        io_out_valid,
  input  logic        io_out_ready,
`ifdef HMMM_MULDIV_EN
  output logic        md_start,
  input  logic        md_done,
`endif
  output logic        halted,
  output logic        illegal
);

  ctrl_state_t  r_state, w_next;
  instr_class_t w_class;
  logic         w_illegal;
  logic         r_halted, r_illegal;
  logic         w_take;

  logic    w_ir_we, w_pc_we, w_rf_we, w_rf_waddr_sel, w_alu_b_sel;
  logic    w_mem_addr_sel, w_mem_we, w_io_in_ready, w_io_out_valid;
  pc_sel_t w_pc_sel;
  wb_sel_t w_wb_sel;
  alu_op_t w_alu_op;
`ifdef HMMM_MULDIV_EN
  logic    r_md_busy, w_md_start;
`endif

  hmmm_decode u_decode (
    .i_instr   (instr),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  always_comb begin
    case (w_class)
      C_JEQZ:  w_take = rx_zero;
      C_JNEZ:  w_take = !rx_zero;
      C_JGTZ:  w_take = !rx_zero && !rx_neg;
      C_JLTZ:  w_take = rx_neg;
      default: w_take = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_next == S_HALT) r_halted  <= 1'b1;
      if (r_state == S_DECODE && w_illegal)        r_illegal <= 1'b1;
    end
  end

`ifdef HMMM_MULDIV_EN
  // busy is low only in the first MD_WAIT cycle, which makes md_start a single pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_md_busy <= 1'b0;
    else        r_md_busy <= (r_state == S_MD_WAIT) && (w_next == S_MD_WAIT);
  end
`endif

  always_comb begin
    w_next         = r_state;
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_sel       = PC_INC;
    w_rf_we        = 1'b0;
    w_rf_waddr_sel = 1'b0;
    w_wb_sel       = WB_ALU;
    w_alu_op       = ALU_ADD;
    w_alu_b_sel    = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_mem_we       = 1'b0;
    w_io_in_ready  = 1'b0;
    w_io_out_valid = 1'b0;
`ifdef HMMM_MULDIV_EN
    w_md_start     = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_ir_we = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        case (w_class)
          C_HALT, C_ILL:   w_next = S_HALT;
          C_READ, C_WRITE: w_next = S_IO_WAIT;
          C_LOADN, C_LOADR, C_STOREN, C_STORER, C_PUSHR: w_next = S_MEM;
`ifdef HMMM_MULDIV_EN
          C_MD:            w_next = S_MD_WAIT;
`endif
          default:         w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_next  = S_FETCH;
        w_pc_we = 1'b1;
        w_rf_we = 1'b1;
        case (w_class)
          C_SETN: w_wb_sel    = WB_IMM;
          C_ADDN: w_alu_b_sel = 1'b1;
          C_COPY: w_wb_sel    = WB_RY;
          C_NEG:  w_alu_op    = ALU_NEG;
          C_SUB:  w_alu_op    = ALU_SUB;
          C_POPR: begin
            w_pc_we        = 1'b0;
            w_rf_waddr_sel = 1'b1;
            w_alu_op       = ALU_SUB;
            w_alu_b_sel    = 1'b1;
            w_next         = S_MEM;
          end
          C_JUMPR: begin
            w_rf_we  = 1'b0;
            w_pc_sel = PC_RX;
          end
          C_JUMPN, C_JEQZ, C_JNEZ, C_JGTZ, C_JLTZ: begin
            w_rf_we  = 1'b0;
            w_pc_sel = w_take ? PC_IMM : PC_INC;
          end
          C_CALLN: begin
            w_wb_sel = WB_PC1;
            w_pc_sel = PC_IMM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_next         = S_WB;
        w_mem_addr_sel = w_class inside {C_LOADR, C_STORER, C_PUSHR, C_POPR};
        case (w_class)
          C_STOREN, C_STORER: begin
            w_mem_we = 1'b1;
            w_pc_we  = 1'b1;
            w_next   = S_FETCH;
          end
          C_PUSHR: w_mem_we = 1'b1;
          default: ;
        endcase
      end
      S_WB: begin
        w_next  = S_FETCH;
        w_rf_we = 1'b1;
        w_pc_we = 1'b1;
        if (w_class == C_PUSHR) begin
          w_rf_waddr_sel = 1'b1;
          w_alu_b_sel    = 1'b1;
        end else begin
          w_wb_sel = WB_MEM;
        end
      end
      S_IO_WAIT: begin
        if (w_class == C_READ) begin
          w_io_in_ready = 1'b1;
          if (io_in_valid) begin
            w_rf_we  = 1'b1;
            w_wb_sel = WB_IO;
            w_pc_we  = 1'b1;
            w_next   = S_FETCH;
          end
        end else begin
          w_io_out_valid = 1'b1;
          if (io_out_ready) begin
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
          end
        end
      end
`ifdef HMMM_MULDIV_EN
      S_MD_WAIT: begin
        w_md_start = !r_md_busy;
        if (md_done) begin
          w_rf_we  = 1'b1;
          w_wb_sel = WB_MD;
          w_pc_we  = 1'b1;
          w_next   = S_FETCH;
        end
      end
`endif
      S_HALT:  ;
      default: w_next = S_FETCH;
    endcase
  end

  // The state register idles in FETCH during reset; rst_n masks the decode so nothing fires then.
  assign ir_we        = rst_n & w_ir_we;
  assign pc_we        = rst_n & w_pc_we;
  assign pc_sel       = rst_n ? w_pc_sel : 2'b00;
  assign rf_we        = rst_n & w_rf_we;
  assign rf_waddr_sel = rst_n & w_rf_waddr_sel;
  assign wb_sel       = rst_n ? w_wb_sel : 3'b000;
  assign alu_op       = rst_n ? w_alu_op : 2'b00;
  assign alu_b_sel    = rst_n & w_alu_b_sel;
  assign mem_addr_sel = rst_n & w_mem_addr_sel;
  assign mem_we       = rst_n & w_mem_we;
  assign io_in_ready  = rst_n & w_io_in_ready;
  assign io_out_valid = rst_n & w_io_out_valid;
`ifdef HMMM_MULDIV_EN
  assign md_start     = rst_n & w_md_start;
`endif
  assign halted       = r_halted;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_hmmm_ctrl.sv
// Directed-vector bench for hmmm_ctrl; builds with or without HMMM_MULDIV_EN.
module tb_hmmm_ctrl;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic       rf_waddr_sel;
    logic [2:0] wb_sel;
    logic [1:0] alu_op;
    logic       alu_b_sel;
    logic       mem_addr_sel;
    logic       mem_we;
    logic       io_in_ready;
    logic       io_out_valid;
    logic       halted;
    logic       illegal;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        rx_zero = 1'b0, rx_neg = 1'b0;
  logic        io_in_valid = 1'b0, io_out_ready = 1'b0;
  logic        ir_we, pc_we, rf_we, rf_waddr_sel, alu_b_sel, mem_addr_sel, mem_we;
  logic        io_in_ready, io_out_valid, halted, illegal;
  logic [1:0]  pc_sel, alu_op;
  logic [2:0]  wb_sel;
`ifdef HMMM_MULDIV_EN
  logic        md_start;
  logic        md_done = 1'b0;
`endif

  ctl_t o, e;
  int   tests = 0;
  int   failed = 0;

  assign o = {ir_we, pc_we, pc_sel, rf_we, rf_waddr_sel, wb_sel, alu_op, alu_b_sel,
              mem_addr_sel, mem_we, io_in_ready, io_out_valid, halted, illegal};

  always #5 clk = ~clk;

  hmmm_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .rx_zero      (rx_zero),
    .rx_neg       (rx_neg),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .rf_waddr_sel (rf_waddr_sel),
    .wb_sel       (wb_sel),
    .alu_op       (alu_op),
    .alu_b_sel    (alu_b_sel),
    .mem_addr_sel (mem_addr_sel),
    .mem_we       (mem_we),
    .io_in_ready  (io_in_ready),
    .io_in_valid  (io_in_valid),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
`ifdef HMMM_MULDIV_EN
    .md_start     (md_start),
    .md_done      (md_done),
`endif
    .halted       (halted),
    .illegal      (illegal)
  );

  // jump table: instruction, flags, expected pc_sel, whether it links (calln)
  logic [15:0] j_ins [11] = '{16'hC220, 16'hC220, 16'hD220, 16'hE220, 16'hE220, 16'hE220,
                              16'hF220, 16'hF220, 16'hB020, 16'h0203, 16'hB120};
  logic        j_z   [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        j_n   [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0]  j_ps  [11] = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1};
  logic        j_lnk [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // ALU table: addn, copy, add, neg, sub
  logic [15:0] a_ins [5] = '{16'h5103, 16'h6120, 16'h6123, 16'h7103, 16'h7123};
  logic [2:0]  a_wb  [5] = '{3'd0, 3'd6, 3'd0, 3'd0, 3'd0};
  logic [1:0]  a_alu [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1};
  logic        a_bs  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instr = 16'h1105;
    repeat (2) @(posedge clk);
    #2;
    e = '0;
    tests++; if (o !== e) begin $display("FAIL reset_idle: got %h exp %h", o, e); failed++; end
    #1 rst_n = 1'b1;
    #1;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL reset_first_fetch: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_setn;
    step;
    e = '0;
    tests++; if (o !== e) begin $display("FAIL setn_decode: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.rf_we = 1'b1; e.wb_sel = 3'd1; e.pc_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL setn_exec: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL setn_refetch: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_alu;
    for (int i = 0; i < 5; i++) begin
      instr = a_ins[i];
      step;
      step;
      e = '0; e.rf_we = 1'b1; e.pc_we = 1'b1;
      e.wb_sel = a_wb[i]; e.alu_op = a_alu[i]; e.alu_b_sel = a_bs[i];
      tests++; if (o !== e) begin $display("FAIL alu_exec[%0d]: got %h exp %h", i, o, e); failed++; end
      step;
    end
  endtask

  task automatic test_jeqzn;
    instr = 16'hC220;
    rx_zero = 1'b1;
    step;
    step;
    e = '0; e.pc_we = 1'b1; e.pc_sel = 2'd1;
    tests++; if (o !== e) begin $display("FAIL jeqzn_taken: got %h exp %h", o, e); failed++; end
    rx_zero = 1'b0;
    #1;
    e = '0; e.pc_we = 1'b1; e.pc_sel = 2'd0;
    tests++; if (o !== e) begin $display("FAIL jeqzn_not_taken: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL jeqzn_refetch: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_jumps;
    for (int i = 0; i < 11; i++) begin
      instr = j_ins[i];
      rx_zero = j_z[i];
      rx_neg = j_n[i];
      step;
      step;
      e = '0; e.pc_we = 1'b1; e.pc_sel = j_ps[i];
      if (j_lnk[i]) begin e.rf_we = 1'b1; e.wb_sel = 3'd3; end
      tests++; if (o !== e) begin $display("FAIL jump_exec[%0d]: got %h exp %h", i, o, e); failed++; end
      step;
    end
    rx_zero = 1'b0;
    rx_neg = 1'b0;
  endtask

  task automatic test_mem;
    instr = 16'h3105;  // storen
    step; step;
    e = '0; e.mem_we = 1'b1; e.pc_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL storen_mem: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL storen_refetch: got %h exp %h", o, e); failed++; end
    instr = 16'h4121;  // storer
    step; step;
    e = '0; e.mem_we = 1'b1; e.pc_we = 1'b1; e.mem_addr_sel = 1'b1;
    tests++; if (o !== e) begin $display("FAIL storer_mem: got %h exp %h", o, e); failed++; end
    step;
    instr = 16'h2105;  // loadn
    step; step;
    e = '0;
    tests++; if (o !== e) begin $display("FAIL loadn_mem: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.rf_we = 1'b1; e.wb_sel = 3'd2; e.pc_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL loadn_wb: got %h exp %h", o, e); failed++; end
    step;
    instr = 16'h4120;  // loadr
    step; step;
    e = '0; e.mem_addr_sel = 1'b1;
    tests++; if (o !== e) begin $display("FAIL loadr_mem: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.rf_we = 1'b1; e.wb_sel = 3'd2; e.pc_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL loadr_wb: got %h exp %h", o, e); failed++; end
    step;
    instr = 16'h4123;  // pushr
    step; step;
    e = '0; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1;
    tests++; if (o !== e) begin $display("FAIL pushr_mem: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.rf_we = 1'b1; e.rf_waddr_sel = 1'b1; e.alu_b_sel = 1'b1; e.pc_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL pushr_wb: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL pushr_refetch: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_popr;
    instr = 16'h44F2;
    step; step;
    e = '0; e.rf_we = 1'b1; e.rf_waddr_sel = 1'b1; e.alu_op = 2'd1; e.alu_b_sel = 1'b1;
    tests++; if (o !== e) begin $display("FAIL popr_exec: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.mem_addr_sel = 1'b1;
    tests++; if (o !== e) begin $display("FAIL popr_mem: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.rf_we = 1'b1; e.wb_sel = 3'd2; e.pc_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL popr_wb: got %h exp %h", o, e); failed++; end
    step;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL popr_refetch: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_read;
    instr = 16'h0301;
    io_in_valid = 1'b0;
    step; step;
    for (int i = 0; i < 4; i++) begin
      e = '0; e.io_in_ready = 1'b1;
      tests++; if (o !== e) begin $display("FAIL read_wait[%0d]: got %h exp %h", i, o, e); failed++; end
      step;
    end
    io_in_valid = 1'b1;
    #1;
    e = '0; e.io_in_ready = 1'b1; e.rf_we = 1'b1; e.wb_sel = 3'd4; e.pc_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL read_accept: got %h exp %h", o, e); failed++; end
    step;
    io_in_valid = 1'b0;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL read_refetch: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_illegal;
    instr = 16'h0005;
    step; step;
    e = '0; e.halted = 1'b1; e.illegal = 1'b1;
    tests++; if (o !== e) begin $display("FAIL illegal_halt: got %h exp %h", o, e); failed++; end
    repeat (3) step;
    tests++; if (o !== e) begin $display("FAIL illegal_absorb: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_halt;
    do_reset;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL halt_reset_fetch: got %h exp %h", o, e); failed++; end
    instr = 16'h0000;
    step; step;
    e = '0; e.halted = 1'b1;
    tests++; if (o !== e) begin $display("FAIL halt_state: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_write_reset;
    do_reset;
    instr = 16'h0302;
    io_out_ready = 1'b0;
    step; step;
    e = '0; e.io_out_valid = 1'b1;
    tests++; if (o !== e) begin $display("FAIL write_wait: got %h exp %h", o, e); failed++; end
    step;
    tests++; if (o !== e) begin $display("FAIL write_hold: got %h exp %h", o, e); failed++; end
    #1 rst_n = 1'b0;
    #1;
    e = '0;
    tests++; if (o !== e) begin $display("FAIL write_async_drop: got %h exp %h", o, e); failed++; end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL write_resume_fetch: got %h exp %h", o, e); failed++; end
    io_out_ready = 1'b1;
    step; step;
    e = '0; e.io_out_valid = 1'b1; e.pc_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL write_same_cycle: got %h exp %h", o, e); failed++; end
    step;
    io_out_ready = 1'b0;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL write_refetch: got %h exp %h", o, e); failed++; end
  endtask

  task automatic test_muldiv;
    do_reset;
    instr = 16'h8123;
    step; step;
`ifdef HMMM_MULDIV_EN
    e = '0;
    tests++; if (o !== e || md_start !== 1'b1) begin
      $display("FAIL md_start_pulse: got %h md_start %b exp %h md_start 1", o, md_start, e); failed++; end
    for (int i = 2; i <= 5; i++) begin
      step;
      tests++; if (o !== e || md_start !== 1'b0) begin
        $display("FAIL md_wait[%0d]: got %h md_start %b exp %h md_start 0", i, o, md_start, e); failed++; end
    end
    step;
    md_done = 1'b1;
    #1;
    e = '0; e.rf_we = 1'b1; e.wb_sel = 3'd5; e.pc_we = 1'b1;
    tests++; if (o !== e || md_start !== 1'b0) begin
      $display("FAIL md_done_wb: got %h md_start %b exp %h md_start 0", o, md_start, e); failed++; end
    step;
    md_done = 1'b0;
    e = '0; e.ir_we = 1'b1;
    tests++; if (o !== e) begin $display("FAIL md_refetch: got %h exp %h", o, e); failed++; end
`else
    e = '0; e.halted = 1'b1; e.illegal = 1'b1;
    tests++; if (o !== e) begin $display("FAIL mul_illegal: got %h exp %h", o, e); failed++; end
`endif
  endtask

  initial begin
    test_reset;
    test_setn;
    test_alu;
    test_jeqzn;
    test_jumps;
    test_mem;
    test_popr;
    test_read;
    test_illegal;
    test_halt;
    test_write_reset;
    test_muldiv;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests %0d failed %0d", tests, failed);
    $fatal(1);
  end

endmodule
